regfile_seq: RTL and testbench

REGFILE_SEQ -- requirements
Module: regfile_seq

---
 rtl/regfile_seq_pkg.sv | 5 +
 rtl/reg4_8.sv | 17 +
 rtl/regfile_seq_alu.sv | 16 +
 rtl/regfile_seq.sv | 66 ++++++
 tb/tb_regfile_seq.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: opcode and FSM state encodings shared by the sequencer and its ALU
package regfile_seq_pkg;
  typedef enum logic [1:0] {OP_LDI, OP_MOV, OP_ADD, OP_SWAP} op_e;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE1, S_WRITE2, S_DONE} state_e;
endpackage

// File: rtl/reg4_8.sv
// reg4_8: four 8-bit registers, two combinational read ports, one synchronous write port
module reg4_8 (
  input  logic       clk,
  input  logic       we,
  input  logic [1:0] nd,
  input  logic [7:0] di,
  input  logic [1:0] n1,
  input  logic [1:0] n2,
  output logic [7:0] q1,
  output logic [7:0] q2
);
  logic [7:0] mem [4];
  always_ff @(posedge clk)
    if (we) mem[nd] <= di;
  assign q1 = mem[n1];
  assign q2 = mem[n2];
endmodule

// File: rtl/regfile_seq_alu.sv
// regfile_seq_alu: first-write data and carry-out for the latched operation
module regfile_seq_alu
  import regfile_seq_pkg::*;
(
  input  op_e        op,
  input  logic [7:0] t1,
  input  logic [7:0] t2,
  input  logic [7:0] imm,
  output logic [7:0] d,
  output logic       c
);
  logic [8:0] sum;
  assign sum = {1'b0, t1} + {1'b0, t2};
  assign d = op == OP_LDI ? imm : op == OP_MOV ? t1 : op == OP_ADD ? sum[7:0] : t2;
  assign c = sum[8];
endmodule

// File: rtl/regfile_seq.sv
// regfile_seq: multi-cycle LDI/MOV/ADD/SWAP sequencer driving an external 4x8 register file
module regfile_seq
  import regfile_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [1:0] rd,
  input  logic [1:0] rs,
  input  logic [1:0] rt,
  input  logic [7:0] imm,
  output logic       busy,
  output logic       done,
  output logic       carry,
  output logic [1:0] n1,
  output logic [1:0] n2,
  input  logic [7:0] q1,
  input  logic [7:0] q2,
  output logic [1:0] nd,
  output logic [7:0] di,
  output logic       reg_we
);
  state_e     st, nx;
  op_e        op_q;
  logic [1:0] rd_q, rs_q, rt_q, nd_q, nd_w;
  logic [7:0] imm_q, t1, t2, di_q, di_w, alu_d;
  logic       alu_c;
  regfile_seq_alu u_alu (.op(op_q), .t1(t1), .t2(t2), .imm(imm_q), .d(alu_d), .c(alu_c));
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      op_q <= OP_LDI;
      {rd_q, rs_q, rt_q, imm_q, t1, t2, nd_q, di_q, carry} <= '0;
    end else begin
      st <= nx;
      if (st == S_IDLE && req) begin
        op_q <= op_e'(op);
        {rd_q, rs_q, rt_q, imm_q} <= {rd, rs, rt, imm};
      end
      if (st == S_READ) {t1, t2} <= {q1, q2};
      if (reg_we) {nd_q, di_q} <= {nd_w, di_w};
      if (st == S_WRITE1 && op_q == OP_ADD) carry <= alu_c;
    end
  end
  always_comb begin
    nx = st;
    case (st)
      S_IDLE:   nx = req ? (op == OP_LDI ? S_WRITE1 : S_READ) : S_IDLE;
      S_READ:   nx = S_WRITE1;
      S_WRITE1: nx = op_q == OP_SWAP ? S_WRITE2 : S_DONE;
      S_WRITE2: nx = S_DONE;
      default:  nx = S_IDLE;
    endcase
  end
  assign busy   = st != S_IDLE;
  assign done   = st == S_DONE;
  assign reg_we = st == S_WRITE1 || st == S_WRITE2;
  assign n1     = rs_q;
  assign n2     = rt_q;
  // SWAP writes Rs first, then Rt with the other captured operand
  assign nd_w   = st == S_WRITE2 ? rt_q : op_q == OP_SWAP ? rs_q : rd_q;
  assign di_w   = st == S_WRITE2 ? t1 : alu_d;
  assign nd     = reg_we ? nd_w : nd_q;
  assign di     = reg_we ? di_w : di_q;
endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: regfile_seq paired with reg4_8, checked every cycle against an operation-level model
module tb_regfile_seq;
  logic       clk, rst, req, busy, done, carry, reg_we;
  logic [1:0] op, rd, rs, rt, n1, n2, nd;
  logic [7:0] imm, q1, q2, di;
  int n_chk = 0, n_err = 0;
  bit armed = 0;

  regfile_seq dut (.clk(clk), .rst(rst), .req(req), .op(op), .rd(rd), .rs(rs), .rt(rt),
    .imm(imm), .busy(busy), .done(done), .carry(carry), .n1(n1), .n2(n2), .q1(q1),
    .q2(q2), .nd(nd), .di(di), .reg_we(reg_we));
  reg4_8 u_rf (.clk(clk), .we(reg_we), .nd(nd), .di(di), .n1(n1), .n2(n2), .q1(q1), .q2(q2));

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {logic busy, we, done, cu, cv; logic [1:0] nd; logic [7:0] di;} rec_t;
  rec_t q[$];
  logic [7:0] m [4];
  bit mv [4] = '{0, 0, 0, 0};
  logic mc = 0;
  logic [1:0] last_nd = 0;
  logic [7:0] last_di = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(bit b, bit we, logic [1:0] a, logic [7:0] d, bit dn, bit cu, bit cv);
    rec_t r;
    r.busy = b; r.we = we; r.nd = a; r.di = d; r.done = dn; r.cu = cu; r.cv = cv;
    return r;
  endfunction

  // Expected per-cycle behaviour of one operation, from the cycle after acceptance onward
  task automatic push_op(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s,
                         input logic [1:0] t, input logic [7:0] im);
    logic [8:0] sum;
    sum = m[s] + m[t];
    if (o != 0) q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    case (o)
      0: q.push_back(mk(1, 1, d, im, 0, 0, 0));
      1: q.push_back(mk(1, 1, d, m[s], 0, 0, 0));
      2: q.push_back(mk(1, 1, d, sum[7:0], 0, 1, sum[8]));
      default: begin
        q.push_back(mk(1, 1, s, m[t], 0, 0, 0));
        q.push_back(mk(1, 1, t, m[s], 0, 0, 0));
      end
    endcase
    q.push_back(mk(1, 0, 0, 0, 1, 0, 0));
  endtask

  always @(negedge clk) if (armed) begin
    rec_t r;
    for (int i = 0; i < 4; i++) if (mv[i]) chk($sformatf("r%0d", i), u_rf.mem[i], m[i]);
    chk("carry", carry, mc);
    r = q.size() != 0 ? q.pop_front() : mk(0, 0, 0, 0, 0, 0, 0);
    chk("busy", busy, r.busy);
    chk("done", done, r.done);
    chk("reg_we", reg_we, r.we);
    if (r.we) begin
      last_nd = r.nd; last_di = r.di; m[r.nd] = r.di; mv[r.nd] = 1;
    end
    chk("nd", nd, last_nd);
    chk("di", di, last_di);
    if (r.cu) mc = r.cv;
    if (rst) begin
      q.delete(); mc = 0; last_nd = 0; last_di = 0;
    end
  end

  task automatic drive(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s,
                       input logic [1:0] t, input logic [7:0] im);
    req = 1; op = o; rd = d; rs = s; rt = t; imm = im;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s,
                       input logic [1:0] t, input logic [7:0] im, input int lat);
    int got;
    got = 0;
    drive(o, d, s, t, im);
    @(posedge clk);
    push_op(o, d, s, t, im);
    #1 req = 0;
    for (int c = 1; c <= 12 && got == 0; c++) begin
      @(negedge clk);
      if (done) got = c;
    end
    chk("latency", got, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; req = 0; op = 0; rd = 0; rs = 0; rt = 0; imm = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; armed = 1;
    do_op(0, 0, 0, 0, 8'h12, 2);
    do_op(0, 1, 0, 0, 8'h34, 2);
    do_op(0, 2, 0, 0, 8'h55, 2);
    chk("ldi_r2", u_rf.mem[2], 8'h55);
    do_op(0, 3, 0, 0, 8'h01, 2);
    do_op(3, 0, 0, 1, 0, 4);
    chk("swap_r0", u_rf.mem[0], 8'h34);
    chk("swap_r1", u_rf.mem[1], 8'h12);
    do_op(0, 1, 0, 0, 8'hFF, 2);
    do_op(2, 1, 1, 3, 0, 3);
    chk("add_r1", u_rf.mem[1], 8'h00);
    chk("add_carry", carry, 1);
    do_op(0, 0, 0, 0, 8'h07, 2);
    chk("ldi_keeps_carry", carry, 1);
    // Req held high through two IDLE visits: one MOV each, separated by one idle cycle
    drive(1, 2, 0, 0, 0);
    @(posedge clk);
    push_op(1, 2, 0, 0, 0);
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    push_op(1, 2, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 req = 0;
    for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
    chk("hold_drained", q.size(), 0);
    chk("mov_r2", u_rf.mem[2], 8'h07);
    @(posedge clk); #1;
    do_op(3, 0, 2, 2, 0, 4);
    chk("swap_same_r2", u_rf.mem[2], 8'h07);
    do_op(2, 3, 0, 2, 0, 3);
    chk("add_r3", u_rf.mem[3], 8'h0E);
    chk("add_nocarry", carry, 0);
    // Abort an ADD while in READ
    drive(2, 1, 0, 3, 0);
    @(posedge clk);
    push_op(2, 1, 0, 3, 0);
    #1 req = 0; rst = 1;
    @(posedge clk);
    #1 rst = 0;
    repeat (4) @(negedge clk);
    chk("abort_r1", u_rf.mem[1], 8'h00);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    // Reset wins over a simultaneous request
    drive(0, 1, 0, 0, 8'hFF);
    rst = 1;
    @(posedge clk);
    #1 rst = 0; req = 0;
    @(negedge clk);
    chk("prio_busy", busy, 0);
    @(posedge clk); #1;
    do_op(0, 1, 0, 0, 8'hAA, 2);
    chk("post_r1", u_rf.mem[1], 8'hAA);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
